// File: rtl/noc_alloc_pkg.sv
// Shared types and helpers for the NoC output allocator.
// Optional feature macro: NOC_ALLOC_TURN_MASK_EN (see noc_output_allocator).
package noc_alloc_pkg;

  typedef enum logic {
    ALLOC_IDLE,
    ALLOC_LOCKED
  } alloc_state_e;

  // Width of an index/counter holding n distinct values, never below 1
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_priority_arbiter.sv
// Round-robin priority pick: first requester at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer.
module rr_priority_arbiter
  import noc_alloc_pkg::*;
#(
  parameter int N = 5,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;

  // Rotate so ptr lands on bit 0, pick lowest set bit, map back
  always_comb begin
    rot   = N'({req_i, req_i} >> ptr_i);
    off   = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && rot[k]) begin
        any_o = 1'b1;
        off   = W'(k);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (W+1)'(N)) begin
      sum = sum - (W+1)'(N);
    end
    idx_o = sum[W-1:0];
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/noc_output_allocator.sv
// Per-output switch allocator: round-robin, wormhole lock, credit tracking.
// Optional macro NOC_ALLOC_TURN_MASK_EN adds the turn_disable input.
module noc_output_allocator
  import noc_alloc_pkg::*;
#(
  parameter  int NUM_INPUTS        = 5,
  parameter  int FLIT_BUFFER_DEPTH = 2,
  localparam int CREDIT_WIDTH      = clog2_min1(FLIT_BUFFER_DEPTH + 1),
  localparam int OWNER_WIDTH       = clog2_min1(NUM_INPUTS)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc_sync,
`ifdef NOC_ALLOC_TURN_MASK_EN
  input  logic [NUM_INPUTS-1:0]   turn_disable,
`endif
  input  logic [NUM_INPUTS-1:0]   req,
  input  logic [NUM_INPUTS-1:0]   req_is_tail,
  input  logic                    credit_in,
  output logic [NUM_INPUTS-1:0]   grant,
  output logic                    send_out,
  output logic                    locked,
  output logic [OWNER_WIDTH-1:0]  lock_owner,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    credit_err
);

  localparam logic [CREDIT_WIDTH-1:0] CRED_MAX =
    CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [OWNER_WIDTH-1:0] LAST_IDX =
    OWNER_WIDTH'(NUM_INPUTS - 1);

  alloc_state_e            state_q, state_d;
  logic [OWNER_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [OWNER_WIDTH-1:0]  owner_q, owner_d;
  logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic                    err_q, err_d;

  logic                    can_send;
  logic [NUM_INPUTS-1:0]   elig;
  logic [NUM_INPUTS-1:0]   arb_gnt;
  logic [OWNER_WIDTH-1:0]  arb_idx;
  logic                    arb_any;

  assign can_send = (credits_q != '0);

`ifdef NOC_ALLOC_TURN_MASK_EN
  assign elig = req & ~turn_disable;
`else
  assign elig = req;
`endif

  rr_priority_arbiter #(
    .N (NUM_INPUTS)
  ) u_arb (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Grant selection, lock transitions and credit bookkeeping
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    credits_d = credits_q;
    err_d     = err_q;
    grant     = '0;

    unique case (state_q)
      ALLOC_IDLE: begin
        if (can_send && arb_any) begin
          grant = arb_gnt;
          if (req_is_tail[arb_idx]) begin
            rr_ptr_d = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
          end else begin
            state_d = ALLOC_LOCKED;
            owner_d = arb_idx;
          end
        end
      end
      ALLOC_LOCKED: begin
        if (can_send && req[owner_q]) begin
          grant[owner_q] = 1'b1;
          if (req_is_tail[owner_q]) begin
            state_d  = ALLOC_IDLE;
            rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
            owner_d  = '0;
          end
        end
      end
      default: state_d = ALLOC_IDLE;
    endcase

    if (rst_noc_sync) begin
      grant = '0;
    end

    send_out = |grant;

    unique case ({send_out, credit_in})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CRED_MAX) begin
          err_d = 1'b1;
        end else begin
          credits_d = credits_q + 1'b1;
        end
      end
      default: credits_d = credits_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q   <= ALLOC_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      credits_q <= CRED_MAX;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  // Credit count can never exceed the downstream buffer depth
  always_ff @(posedge clk_noc) begin
    if (!rst_noc_sync) begin
      assert (credits_q <= CRED_MAX)
        else $error("credit count above buffer depth");
    end
  end

  assign locked     = (state_q == ALLOC_LOCKED);
  assign lock_owner = owner_q;
  assign credits    = credits_q;
  assign credit_err = err_q;

endmodule
